// File: rtl/rgb_pwm_if.sv
// Colour targets from the colour cycler plus the LED pins and busy flag of the fader.
interface rgb_pwm_if;
  logic red_in;
  logic green_in;
  logic blue_in;
  logic red_out;
  logic green_out;
  logic blue_out;
  logic busy;

  modport master (
    output red_in, green_in, blue_in,
    input  red_out, green_out, blue_out, busy
  );

  modport slave (
    input  red_in, green_in, blue_in,
    output red_out, green_out, blue_out, busy
  );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Crossfading RGB LED driver: each on/off colour target becomes a linear duty ramp,
// rendered through one shared PWM counter with a registered pin stage.
module rgb_pwm_fader #(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 3922,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic     clk,
  input  logic     rst,
  rgb_pwm_if.slave bus
);
  localparam int STEP_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_INTERVAL - 1);
  localparam logic                UNLIT     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_ON, ST_FALL} state_t;

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [STEP_W-1:0]   step_cnt_reg;
  logic                step_tick;
  logic [2:0]          ch_in;
  state_t              state_reg  [3];
  state_t              state_next [3];
  logic [PWM_BITS-1:0] duty_reg   [3];
  logic [PWM_BITS-1:0] duty_next  [3];
  logic [2:0]          lit;
  logic [2:0]          ramping;
  logic [2:0]          pin_reg;

  assign ch_in     = {bus.blue_in, bus.green_in, bus.red_in};
  assign step_tick = (step_cnt_reg == STEP_LAST);

  // Shared timebase: both counters free-run and ignore input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg  <= '0;
      step_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;
      step_cnt_reg <= step_tick ? '0 : step_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      state_next[ch] = state_reg[ch];
      duty_next[ch]  = duty_reg[ch];
      case (state_reg[ch])
        ST_OFF: begin
          duty_next[ch] = '0;
          if (ch_in[ch]) state_next[ch] = ST_RISE;
        end
        ST_RISE: begin
          // A reversal takes priority over a coincident step.
          if (!ch_in[ch]) begin
            state_next[ch] = ST_FALL;
          end else if (step_tick) begin
            duty_next[ch] = duty_reg[ch] + 1'b1;
            if (duty_reg[ch] == DUTY_MAX - 1'b1) state_next[ch] = ST_ON;
          end
        end
        ST_ON: begin
          duty_next[ch] = DUTY_MAX;
          if (!ch_in[ch]) state_next[ch] = ST_FALL;
        end
        ST_FALL: begin
          if (ch_in[ch]) begin
            state_next[ch] = ST_RISE;
          end else if (step_tick) begin
            duty_next[ch] = duty_reg[ch] - 1'b1;
            if (duty_reg[ch] == DUTY_ONE) state_next[ch] = ST_OFF;
          end
        end
        default: begin
          state_next[ch] = ST_OFF;
          duty_next[ch]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        state_reg[ch] <= ST_OFF;
        duty_reg[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        state_reg[ch] <= state_next[ch];
        duty_reg[ch]  <= duty_next[ch];
      end
    end
  end

  // ON forces the pin lit so full brightness has no dark slot at pwm_cnt == MAX.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign lit[gi]     = (state_reg[gi] == ST_ON) || (pwm_cnt_reg < duty_reg[gi]);
    assign ramping[gi] = (state_reg[gi] == ST_RISE) || (state_reg[gi] == ST_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_reg <= {3{UNLIT}};
    end else begin
      pin_reg <= lit ^ {3{UNLIT}};
    end
  end

  assign bus.red_out   = pin_reg[0];
  assign bus.green_out = pin_reg[1];
  assign bus.blue_out  = pin_reg[2];
  assign bus.busy      = |ramping;
endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream of the colour-cycling state machine.
- Takes its three on/off colour outputs (red, green, blue) and drives the RGB LED pins with PWM.
- Each channel's brightness ramps linearly up or down instead of switching hard, so colour changes crossfade.
- One shared PWM counter and one shared ramp prescaler; an independent ramp FSM and duty register per channel.

Parameters:
PWM_BITS, 8, width of PWM counter and duty registers; PWM period = 2^PWM_BITS clocks; MAX = 2^PWM_BITS-1
STEP_INTERVAL, 3922, clocks between duty steps; full 0->MAX ramp = MAX*STEP_INTERVAL clocks (~1.0 M at defaults, ~83 ms at 12 MHz)
ACTIVE_LOW, 1, 1: LED pins are active-low (lit = 0); 0: lit = 1

Ports:
clk  input  1  system clock (12 MHz on board)
rst  input  1  asynchronous, active-high reset
red_in  input  1  target red on/off from colour cycler, same clock domain
green_in  input  1  target green on/off
blue_in  input  1  target blue on/off
red_out  output  1  red LED pin, registered
green_out  output  1  green LED pin, registered
blue_out  output  1  blue LED pin, registered
busy  output  1  high while any channel is in RISE or FALL

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, on rst.
- Reset values:
  - pwm_cnt=0, step_cnt=0.
  - All duty=0, all channel states OFF.
  - All *_out at unlit level (1 if ACTIVE_LOW, else 0).
  - busy=0.
- Reset mid-ramp aborts immediately to these values. Ramping resumes from duty 0 on the first clock after release if the input is high.
- pwm_cnt: PWM_BITS wide, increments every clock, wraps MAX->0.
- step_cnt: counts 0..STEP_INTERVAL-1, then wraps to 0.
  - step_tick = (step_cnt == STEP_INTERVAL-1), combinational, one cycle wide.
  - Free-running; never restarted by input changes.
- Per-channel FSM, states OFF, RISE, ON, FALL. "in" is the channel input. All transitions occur on the clock edge:
  - OFF: in=1 -> RISE; otherwise stay. duty held at 0.
  - RISE:
    - in=0 -> FALL. No duty change that cycle, even on step_tick.
    - Else on step_tick: duty <= duty+1. If duty == MAX-1, also go to ON at the same edge.
  - ON: in=0 -> FALL; otherwise stay. duty held at MAX.
  - FALL:
    - in=1 -> RISE. No duty change that cycle.
    - Else on step_tick: duty <= duty-1. If duty == 1, also go to OFF at the same edge.
  - Reversal continues from the current duty with no jump.
  - duty never wraps; it saturates within 0..MAX by construction.
  - Input pulses shorter than one clock are not possible (synchronous input). Every sampled change is honoured.
- PWM output:
  - lit = (state == ON) | (pwm_cnt < duty), evaluated on current registers.
  - *_out <= lit XOR ACTIVE_LOW. One clock of latency from register values to pin.
  - duty=0 in OFF: never lit.
  - ON: solidly lit; no 1/2^PWM_BITS dark gap.
  - Duty k (0<k<MAX) in RISE/FALL: lit exactly k clocks per PWM period.
- busy = any channel in RISE or FALL. Combinational from state registers.
- Channels are fully independent. Yellow (red+green) ramps both channels in parallel.

Test Plan:
1. Reset with PWM_BITS=4, STEP_INTERVAL=3, ACTIVE_LOW=1 -> all *_out=1, busy=0. Assert rst mid-ramp at duty 7 -> next sampled edge shows outputs 1, busy 0, duty 0.
2. red_in 0->1, held -> busy rises next edge. duty reaches 15 after exactly 15 step_ticks (<=45 clocks, tick-phase aligned). State ON; red_out constant 0; busy 0.
3. Hold duty at 4 (drop STEP_INTERVAL large) -> red_out low for exactly 4 of every 16 clocks, aligned to pwm_cnt 0..3 plus one cycle of latency.
4. Reversal: red_in falls while RISE at duty 6, coinciding with step_tick -> duty stays 6 that cycle, state FALL. Then decrements 5,4,..0 -> OFF, busy 0.
5. Yellow->green: red_in=1, green_in=1 both ON; drop red_in -> red ramps down over 15 ticks while green_out stays solidly lit.
6. ACTIVE_LOW=0: after reset outputs 0; ON channel outputs constant 1; duty 4 gives 4 high clocks per period.
